// File: rtl/keys_pkg.sv
// keys_pkg: shared key-count default, id width helper, id type and output slot states
package keys_pkg;
  localparam int KEY_N = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int KEY_IDW = clog2(KEY_N);
  typedef logic [KEY_IDW-1:0] key_id_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);
  logic [IDW-1:0] j;
  // Walk offsets from farthest to nearest so the nearest set request at/after ptr wins
  always_comb begin
    gnt_idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % N);
      if (req[j]) gnt_idx = j;
    end
  end
  assign gnt_any = |req;
  assign gnt_onehot = gnt_any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: queues one pending event per key and serialises them round-robin onto a valid/ready port
module key_event_arbiter
  import keys_pkg::*;
#(
  parameter int N     = KEY_N,
  parameter int IDW   = KEY_IDW,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     key_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  input  logic             clr_drop,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  slot_state_e      state_q, state_d;
  logic [N-1:0]     pending_q, pending_d, gnt_onehot, grant, drop;
  logic [IDW-1:0]   id_q, id_d, ptr_q, ptr_d, gnt_idx;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             gnt_any, load;
  int               drop_sum;
  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req        (pending_q),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );
  // Next state: a granted key clears its pending bit unless re-pulsed; a pulse on a still-pending key is a drop
  always_comb begin
    load = gnt_any && (state_q == SLOT_EMPTY || evt_ready);
    grant = load ? gnt_onehot : '0;
    drop = key_pulse & pending_q & ~grant;
    pending_d = (pending_q & ~grant) | key_pulse;
    state_d = load ? SLOT_FULL : evt_ready ? SLOT_EMPTY : state_q;
    id_d = load ? gnt_idx : id_q;
    ptr_d = !load ? ptr_q : gnt_idx == IDW'(N - 1) ? '0 : gnt_idx + IDW'(1);
    drop_sum = (clr_drop ? 0 : int'(drop_q)) + $countones(drop);
    drop_d = drop_sum > CNT_MAX ? CNT_W'(CNT_MAX) : CNT_W'(drop_sum);
  end
  // State registers; reset discards all pending events and the slot contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      pending_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      drop_q <= drop_d;
    end
  end
  assign evt_valid = state_q == SLOT_FULL;
  assign evt_id = id_q;
  assign drop_cnt = drop_q;
endmodule
